// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between issue logic and the multiply/divide unit
interface muldiv_if #(parameter int XLEN = 32);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [4:0]      rd_in;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;
  modport master (output start, funct3, rs1_data, rs2_data, rd_in, input busy, done, result, rd_out);
  modport slave (input start, funct3, rs1_data, rs2_data, rd_in, output busy, done, result, rd_out);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide; MULDIV_EARLY_OUT_EN lets div-by-zero/overflow skip the iterations
module muldiv_unit #(parameter int XLEN = 32) (
  input logic    clk,
  input logic    reset,
  muldiv_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
  state_t            state, state_nx;
  logic [2:0]        op;
  logic [4:0]        rd;
  logic [4:0]        cnt;
  logic              sa, sb, dz, ovf;
  logic [XLEN-1:0]   a_raw, b_mag;
  logic [2*XLEN-1:0] acc;
  logic              in_div, in_sa, in_sb, in_dz, in_ovf, skip;
  logic [XLEN-1:0]   in_a_mag, in_b_mag;
  logic [XLEN:0]     mul_sum, div_sh;
  logic [XLEN+1:0]   div_diff;
  logic [2*XLEN-1:0] mul_nx, div_nx, prod;
  logic [XLEN-1:0]   quo, rem, fin_res;
  // decode the incoming request: operand signedness, magnitudes and special divide cases
  always_comb begin
    in_div   = bus.funct3[2];
    in_sa    = bus.rs1_data[XLEN-1] & (in_div ? ~bus.funct3[0] : bus.funct3[1] ^ bus.funct3[0]);
    in_sb    = bus.rs2_data[XLEN-1] & (in_div ? ~bus.funct3[0] : bus.funct3[1:0] == 2'b01);
    in_a_mag = in_sa ? -bus.rs1_data : bus.rs1_data;
    in_b_mag = in_sb ? -bus.rs2_data : bus.rs2_data;
    in_dz    = in_div & (bus.rs2_data == '0);
    in_ovf   = in_div & ~bus.funct3[0] & (bus.rs1_data == {1'b1, {(XLEN-1){1'b0}}}) & (&bus.rs2_data);
`ifdef MULDIV_EARLY_OUT_EN
    skip     = in_dz | in_ovf;
`else
    skip     = 1'b0;
`endif
  end
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  // next state: 32 iterations in CALC, one correction cycle in FIN
  always_comb
    state_nx = state == IDLE ? (bus.start ? (skip ? FIN : CALC) : IDLE) :
               state == CALC ? (&cnt ? FIN : CALC) : IDLE;
  // outputs decoded from state
  always_comb bus.busy = state != IDLE;
  // one iteration step: acc low half holds multiplier/dividend bits, high half the partial product/remainder
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, acc[0] ? b_mag : {XLEN{1'b0}}};
    mul_nx   = {mul_sum, acc[XLEN-1:1]};
    div_sh   = acc[2*XLEN-1:XLEN-1];
    div_diff = {1'b0, div_sh} - {2'b0, b_mag};
    div_nx   = div_diff[XLEN+1] ? {div_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0} : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  end
  // final sign correction and special-case override
  always_comb begin
    prod    = (sa ^ sb) ? -acc : acc;
    quo     = (sa ^ sb) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem     = sa ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    fin_res = dz ? (op[1] ? a_raw : {XLEN{1'b1}}) :
              ovf ? (op[1] ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}}) :
              op[2] ? (op[1] ? rem : quo) :
              (op[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
  end
  // datapath: capture on accepted start, iterate in CALC, publish in FIN
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      op         <= '0;
      rd         <= '0;
      cnt        <= '0;
      sa         <= 1'b0;
      sb         <= 1'b0;
      dz         <= 1'b0;
      ovf        <= 1'b0;
      a_raw      <= '0;
      b_mag      <= '0;
      acc        <= '0;
      bus.done   <= 1'b0;
      bus.result <= '0;
      bus.rd_out <= '0;
    end else begin
      bus.done <= state == FIN;
      if (state == IDLE && bus.start) begin
        op    <= bus.funct3;
        rd    <= bus.rd_in;
        cnt   <= '0;
        sa    <= in_sa;
        sb    <= in_sb;
        dz    <= in_dz;
        ovf   <= in_ovf;
        a_raw <= bus.rs1_data;
        b_mag <= in_b_mag;
        acc   <= {{XLEN{1'b0}}, in_a_mag};
      end
      if (state == CALC) begin
        acc <= op[2] ? div_nx : mul_nx;
        cnt <= cnt + 5'd1;
      end
      if (state == FIN) begin
        bus.result <= fin_res;
        bus.rd_out <= rd;
      end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed checks of muldiv_unit results, latency, handshake and reset abort
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  muldiv_if bus();
  muldiv_unit dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int SPEC_LAT = 1;
`else
  localparam int SPEC_LAT = 33;
`endif
  typedef struct {logic [2:0] f3; logic [31:0] a; logic [31:0] b; logic [31:0] exp; logic sp;} vec_t;
  vec_t vecs[15] = '{
    '{3'd0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0},
    '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0},
    '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0},
    '{3'd2, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 1'b0},
    '{3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0},
    '{3'd6, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0},
    '{3'd5, 32'hFFFFFFF9, 32'h00000002, 32'h7FFFFFFC, 1'b0},
    '{3'd7, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 1'b0},
    '{3'd4, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0},
    '{3'd6, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 1'b0},
    '{3'd0, 32'h12345678, 32'h00000010, 32'h23456780, 1'b0},
    '{3'd4, 32'h00001234, 32'h00000000, 32'hFFFFFFFF, 1'b1},
    '{3'd7, 32'h00001234, 32'h00000000, 32'h00001234, 1'b1},
    '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1},
    '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1}
  };
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic launch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    bus.start = 1'b1;
    bus.funct3 = f3;
    bus.rs1_data = a;
    bus.rs2_data = b;
    bus.rd_in = rd;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.rs1_data = $urandom;
    bus.rs2_data = $urandom;
    bus.rd_in = 5'(~rd);
  endtask
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus.done && n < 100);
  endtask
  initial begin
    int n;
    logic saw;
    bus.start = 1'b0;
    bus.funct3 = '0;
    bus.rs1_data = '0;
    bus.rs2_data = '0;
    bus.rd_in = '0;
    #12;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_rd", 32'(bus.rd_out), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    foreach (vecs[i]) begin
      @(negedge clk);
      launch(vecs[i].f3, vecs[i].a, vecs[i].b, 5'(i + 5));
      check($sformatf("busy_%0d", i), 32'(bus.busy), 32'(vecs[i].sp && SPEC_LAT == 1 ? 1'b1 : 1'b1));
      wait_done(n);
      check($sformatf("res_%0d", i), bus.result, vecs[i].exp);
      check($sformatf("rd_%0d", i), 32'(bus.rd_out), 32'(i + 5));
      check($sformatf("lat_%0d", i), 32'(n), 32'(vecs[i].sp ? SPEC_LAT : 33));
      @(posedge clk);
      #1;
      check($sformatf("done_drop_%0d", i), 32'(bus.done), 32'd0);
    end
    @(negedge clk);
    launch(3'd0, 32'd6, 32'd7, 5'd9);
    repeat (5) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.funct3 = 3'd0;
    bus.rs1_data = 32'd100;
    bus.rs2_data = 32'd100;
    bus.rd_in = 5'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(n);
    check("ignore_res", bus.result, 32'd42);
    check("ignore_rd", 32'(bus.rd_out), 32'd9);
    check("ignore_lat", 32'(n + 6), 32'd33);
    launch(3'd5, 32'd100, 32'd7, 5'd11);
    check("b2b_busy", 32'(bus.busy), 32'd1);
    wait_done(n);
    check("b2b_res", bus.result, 32'd14);
    check("b2b_rd", 32'(bus.rd_out), 32'd11);
    check("b2b_lat", 32'(n), 32'd33);
    @(negedge clk);
    launch(3'd0, 32'd3, 32'd5, 5'd2);
    repeat (9) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_result", bus.result, 32'd0);
    check("abort_rd", 32'(bus.rd_out), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      saw |= bus.done;
    end
    check("abort_no_done", 32'(saw), 32'd0);
    launch(3'd0, 32'd3, 32'd4, 5'd7);
    wait_done(n);
    check("post_rst_res", bus.result, 32'd12);
    check("post_rst_rd", 32'(bus.rd_out), 32'd7);
    check("post_rst_lat", 32'(n), 32'd33);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
